life_scheduler: RTL and testbench
=================================

LIFE_SCHEDULER -- requirements
Module: life_scheduler

Interface
REQ-001 SHALL have parameter PACE_CYCLES, default 1000, meaning idle cycles inserted between generations in run mode (0 allowed).
REQ-002 SHALL have parameter GEN_W, default 16, meaning width of the generation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid  input  1  request to load a new board.
REQ-006 SHALL have port load_board  input  64  board to load; bit index = row*8+col.
REQ-007 SHALL have port load_ready  output  1  high exactly when state is IDLE.
REQ-008 SHALL have port step  input  1  single-generation request, sampled in IDLE.
REQ-009 SHALL have port run  input  1  level; continuous paced generations while high.
REQ-010 SHALL have port eval_row  output  3  row of the cell under evaluation (idx[5:3]).
REQ-011 SHALL have port eval_col  output  3  column of the cell under evaluation (idx[2:0]).
REQ-012 SHALL have port eval_board  output  64  committed board driven to the evaluator; equals board.
REQ-013 SHALL have port eval_cur  output  1  board[idx].
REQ-014 SHALL have port eval_next  input  1  evaluator result for (eval_row, eval_col), combinational, same cycle.
REQ-015 SHALL have port board  output  64  committed board state.
REQ-016 SHALL have port gen_count  output  GEN_W  generations committed since load or reset.
REQ-017 SHALL have port gen_done  output  1  one-cycle pulse per commit.
REQ-018 SHALL have port busy  output  1  high when state is not IDLE.
REQ-019 SHALL have port still  output  1  last commit produced a board equal to its predecessor.
REQ-020 SHALL have port empty  output  1  board == 0.

Function
REQ-021 SHALL implement states IDLE, SCAN, COMMIT, PACE.
REQ-022 IDLE: load_valid -> board<=load_board, gen_count<=0, still<=0; stay IDLE.
REQ-023 IDLE with load_valid low: step or run high -> SCAN with idx<=0.
REQ-024 IDLE: load_valid has priority over step/run in the same cycle; the step is dropped, not queued.
REQ-025 SCAN: each cycle shadow[idx]<=eval_next and idx increments; idx==63 -> COMMIT.
REQ-026 SCAN: board SHALL NOT change; shadow SHALL be fully overwritten, with no OR-accumulation of prior contents.
REQ-027 COMMIT, one cycle:
- board<=shadow
- gen_count<=gen_count+1, wrapping modulo 2^GEN_W
- still<=(shadow==board)
- gen_done=1 in the following cycle only
REQ-028 COMMIT exit: run high and PACE_CYCLES>0 -> PACE; run high and PACE_CYCLES==0 -> SCAN (idx=0); run low -> IDLE.
REQ-029 PACE: down-counter loaded with PACE_CYCLES-1; reaches 0 -> SCAN; run low in any PACE cycle -> IDLE next cycle.
REQ-030 Latency: step accepted at edge E0 -> board/gen_count update at edge E0+65; gen_done high for the cycle after E0+65.
REQ-031 Run-mode period between gen_done pulses SHALL be 65+PACE_CYCLES cycles.
REQ-032 run falling during SCAN SHALL NOT abort; the generation completes and commits, then -> IDLE.
REQ-033 load_valid and step SHALL be ignored while busy; load_ready=0 outside IDLE.
REQ-034 empty SHALL be combinational from board.

Reset
REQ-035 rst_n low SHALL immediately force all of the following:
- state=IDLE, idx=0, pace counter=0
- board=0, shadow=0, gen_count=0
- gen_done=0, still=0, busy=0
REQ-036 Under reset, empty=1 and load_ready=1.
REQ-037 Reset mid-SCAN or mid-PACE SHALL discard the partial shadow with no commit.

Verification
REQ-038 Blinker: load bits{17,18,19}, step, golden toroidal evaluator -> at E0+65 board=bits{10,18,26}, gen_count=1, one gen_done pulse, still=0.
REQ-039 Block: load bits{0,1,8,9}, step -> board unchanged, still=1, gen_count=1.
REQ-040 Empty board, step -> board=0, empty=1, still=1.
REQ-041 PACE_CYCLES=4, run held high -> gen_done every 69 cycles; drop run in PACE -> IDLE next cycle with busy=0.
REQ-042 Contention checks:
- load_valid during SCAN -> ignored, load_ready=0
- load_valid+step in same IDLE cycle -> board loaded, no SCAN
- GEN_W=2, 4 steps -> gen_count wraps to 0
REQ-043 rst_n low at idx=30 in SCAN -> all outputs at reset values asynchronously; a following step scans from idx 0.

Source files
------------

// File: rtl/life_scheduler_if.sv
// Scheduler <-> host/evaluator bundle; board bit index = row*8+col.
// master is the host/evaluator side, slave is the scheduler.
interface life_scheduler_if #(
  parameter int GEN_W = 16
);
  logic             load_valid;
  logic [63:0]      load_board;
  logic             load_ready;
  logic             step;
  logic             run;
  logic [2:0]       eval_row;
  logic [2:0]       eval_col;
  logic [63:0]      eval_board;
  logic             eval_cur;
  logic             eval_next;
  logic [63:0]      board;
  logic [GEN_W-1:0] gen_count;
  logic             gen_done;
  logic             busy;
  logic             still;
  logic             empty;

  modport master (
    output load_valid, load_board, step, run, eval_next,
    input  load_ready, eval_row, eval_col, eval_board, eval_cur,
           board, gen_count, gen_done, busy, still, empty
  );

  modport slave (
    input  load_valid, load_board, step, run, eval_next,
    output load_ready, eval_row, eval_col, eval_board, eval_cur,
           board, gen_count, gen_done, busy, still, empty
  );
endinterface

// File: rtl/life_scheduler.sv
// Game-of-life generation scheduler: serial 64-cell scan into a shadow board, then commit.
// Step->commit latency 65 cycles; loads/steps only accepted in IDLE (load_ready), ignored while busy.
module life_scheduler #(
  parameter int PACE_CYCLES = 1000,
  parameter int GEN_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  life_scheduler_if.slave bus
);
  localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'((PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, PACE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        idx_q;
  logic [PACE_W-1:0] pace_q;
  logic [63:0]       board_q;
  logic [63:0]       shadow_q;
  logic [GEN_W-1:0]  gen_q;
  logic              gen_done_q;
  logic              still_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // load_valid wins over step/run; a dropped step is not remembered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.load_valid && (bus.step || bus.run)) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == 6'd63) state_d = COMMIT;
      end
      COMMIT: begin
        if (!bus.run)            state_d = IDLE;
        else if (PACE_CYCLES > 0) state_d = PACE;
        else                     state_d = SCAN;
      end
      PACE: begin
        if (!bus.run)            state_d = IDLE;
        else if (pace_q == '0)   state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pace_q     <= '0;
      board_q    <= '0;
      shadow_q   <= '0;
      gen_q      <= '0;
      gen_done_q <= 1'b0;
      still_q    <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (bus.load_valid) begin
            board_q <= bus.load_board;
            gen_q   <= '0;
            still_q <= 1'b0;
          end
        end
        SCAN: begin
          // Every cell is written once per generation, so no clear is needed between scans.
          shadow_q[idx_q] <= bus.eval_next;
          idx_q           <= idx_q + 6'd1;
        end
        COMMIT: begin
          board_q    <= shadow_q;
          gen_q      <= gen_q + GEN_W'(1);
          still_q    <= (shadow_q == board_q);
          gen_done_q <= 1'b1;
          idx_q      <= '0;
          pace_q     <= PACE_LOAD;
        end
        PACE: begin
          idx_q <= '0;
          if (pace_q != '0) pace_q <= pace_q - PACE_W'(1);
        end
        default: idx_q <= '0;
      endcase
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.eval_row   = idx_q[5:3];
  assign bus.eval_col   = idx_q[2:0];
  assign bus.eval_board = board_q;
  assign bus.eval_cur   = board_q[idx_q];
  assign bus.board      = board_q;
  assign bus.gen_count  = gen_q;
  assign bus.gen_done   = gen_done_q;
  assign bus.still      = still_q;
  assign bus.empty      = (board_q == 64'd0);
endmodule

// File: tb/tb_life_scheduler.sv
// Two schedulers (PACE=4/GEN_W=2 and PACE=0/GEN_W=16) with a toroidal life evaluator,
// checked against a whole-board reference model and cycle-count expectations.
module tb_life_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_valid = 1'b0;
  logic [63:0] load_board = '0;
  logic        step = 1'b0;
  logic        run_a = 1'b0;
  logic        run_b = 1'b0;

  life_scheduler_if #(.GEN_W(2))  ifa ();
  life_scheduler_if #(.GEN_W(16)) ifb ();

  function automatic logic cell_next(input logic [63:0] b, input int r, input int c);
    int n;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0))
          n += int'(b[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
    return b[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
  endfunction

  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    for (int i = 0; i < 64; i++) nb[i] = cell_next(b, i / 8, i % 8);
    return nb;
  endfunction

  assign ifa.load_valid = load_valid;
  assign ifa.load_board = load_board;
  assign ifa.step       = step;
  assign ifa.run        = run_a;
  assign ifa.eval_next  = cell_next(ifa.eval_board, int'(ifa.eval_row), int'(ifa.eval_col));
  assign ifb.load_valid = load_valid;
  assign ifb.load_board = load_board;
  assign ifb.step       = step;
  assign ifb.run        = run_b;
  assign ifb.eval_next  = cell_next(ifb.eval_board, int'(ifb.eval_row), int'(ifb.eval_col));

  life_scheduler #(.PACE_CYCLES(4), .GEN_W(2))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  life_scheduler #(.PACE_CYCLES(0), .GEN_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mb_a = '0, mb_b = '0;
  int          gen_a = 0, gen_b = 0;
  logic        st_a = 1'b0, st_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_board_a"}, ifa.board, mb_a);
    chk({tag, "_board_b"}, ifb.board, mb_b);
    chk({tag, "_gen_a"}, 64'(ifa.gen_count), 64'(gen_a % 4));
    chk({tag, "_gen_b"}, 64'(ifb.gen_count), 64'(gen_b % 65536));
    chk({tag, "_still_a"}, 64'(ifa.still), 64'(st_a));
    chk({tag, "_still_b"}, 64'(ifb.still), 64'(st_b));
    chk({tag, "_empty_a"}, 64'(ifa.empty), 64'(mb_a == 64'd0));
  endtask

  task automatic do_load(input logic [63:0] b);
    @(negedge clk);
    load_valid = 1'b1;
    load_board = b;
    @(negedge clk);
    load_valid = 1'b0;
    mb_a = b; mb_b = b; gen_a = 0; gen_b = 0; st_a = 1'b0; st_b = 1'b0;
    chk_state("load");
  endtask

  task automatic do_step();
    logic [63:0] na, nb;
    na = life_next(mb_a);
    nb = life_next(mb_b);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_busy_a", 64'(ifa.busy), 64'd1);
    chk("step_busy_b", 64'(ifb.busy), 64'd1);
    repeat (20) @(negedge clk);
    chk("scan_row", 64'(ifa.eval_row), 64'd2);
    chk("scan_col", 64'(ifa.eval_col), 64'd4);
    chk("scan_cur", 64'(ifa.eval_cur), 64'(mb_a[20]));
    chk("scan_eval_board", ifa.eval_board, mb_a);
    chk("scan_ready", 64'(ifa.load_ready), 64'd0);
    load_valid = 1'b1;
    load_board = {$urandom, $urandom};
    @(negedge clk);
    load_valid = 1'b0;
    chk("scan_load_ignored", ifa.board, mb_a);
    repeat (43) @(negedge clk);
    chk("pre_commit_board", ifa.board, mb_a);
    chk("pre_commit_done", 64'(ifa.gen_done), 64'd0);
    @(negedge clk);
    st_a = (na == mb_a); st_b = (nb == mb_b);
    mb_a = na; mb_b = nb; gen_a++; gen_b++;
    chk_state("commit");
    chk("commit_done_a", 64'(ifa.gen_done), 64'd1);
    chk("commit_done_b", 64'(ifb.gen_done), 64'd1);
    chk("commit_idle", 64'(ifa.busy), 64'd0);
    @(negedge clk);
    chk("done_pulse_a", 64'(ifa.gen_done), 64'd0);
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? ifb.gen_done : ifa.gen_done) && cyc < 300);
    chk("gen_done_seen", 64'(sel ? ifb.gen_done : ifa.gen_done), 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_board"}, ifa.board, 64'd0);
    chk({tag, "_gen"}, 64'(ifb.gen_count), 64'd0);
    chk({tag, "_busy"}, 64'(ifa.busy), 64'd0);
    chk({tag, "_ready"}, 64'(ifb.load_ready), 64'd1);
    chk({tag, "_empty"}, 64'(ifa.empty), 64'd1);
    chk({tag, "_done"}, 64'(ifa.gen_done), 64'd0);
    chk({tag, "_still"}, 64'(ifb.still), 64'd0);
    chk({tag, "_idx"}, 64'({ifa.eval_row, ifa.eval_col}), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b;
    int cyc;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    b = 64'h0000_0000_000E_0000;
    do_load(b);
    do_step();
    chk("blinker_board", ifa.board, 64'h0000_0000_0404_0400);
    chk("blinker_still", 64'(ifa.still), 64'd0);

    do_load(64'h0000_0000_0000_0303);
    do_step();
    chk("block_board", ifb.board, 64'h0000_0000_0000_0303);
    chk("block_still", 64'(ifb.still), 64'd1);

    do_load(64'd0);
    do_step();
    chk("empty_flag", 64'(ifa.empty), 64'd1);
    chk("empty_still", 64'(ifa.still), 64'd1);

    // load and step in the same IDLE cycle: load wins, step is dropped
    b = {$urandom, $urandom};
    @(negedge clk);
    load_valid = 1'b1; load_board = b; step = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; step = 1'b0;
    mb_a = b; mb_b = b; gen_a = 0; gen_b = 0; st_a = 1'b0; st_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("ld_step_busy", 64'(ifa.busy), 64'd0);
    chk_state("ld_step");

    for (int k = 0; k < 3; k++) begin
      do_load({$urandom, $urandom});
      for (int s = 0; s < 5; s++) do_step();
    end

    // run mode on the PACE_CYCLES=4 instance
    do_load({$urandom, $urandom});
    @(negedge clk);
    run_a = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_done(1'b0, cyc);
      chk("run_a_period", 64'(cyc), (g == 0) ? 64'd66 : 64'd69);
      st_a = (life_next(mb_a) == mb_a); mb_a = life_next(mb_a); gen_a++;
      chk("run_a_board", ifa.board, mb_a);
      chk("run_a_gen", 64'(ifa.gen_count), 64'(gen_a % 4));
    end
    @(negedge clk);
    chk("pace_busy", 64'(ifa.busy), 64'd1);
    run_a = 1'b0;
    @(negedge clk);
    chk("pace_abort_busy", 64'(ifa.busy), 64'd0);
    chk("pace_abort_ready", 64'(ifa.load_ready), 64'd1);
    repeat (80) @(negedge clk);
    chk_state("after_run_a");

    // run mode on the PACE_CYCLES=0 instance; run drops mid-scan
    do_load({$urandom, $urandom});
    @(negedge clk);
    run_b = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_done(1'b1, cyc);
      chk("run_b_period", 64'(cyc), (g == 0) ? 64'd66 : 64'd65);
      st_b = (life_next(mb_b) == mb_b); mb_b = life_next(mb_b); gen_b++;
      chk("run_b_board", ifb.board, mb_b);
    end
    run_b = 1'b0;
    wait_done(1'b1, cyc);
    chk("run_b_last_period", 64'(cyc), 64'd65);
    st_b = (life_next(mb_b) == mb_b); mb_b = life_next(mb_b); gen_b++;
    chk("run_b_idle", 64'(ifb.busy), 64'd0);
    repeat (70) @(negedge clk);
    chk_state("after_run_b");

    // asynchronous reset at idx 30 of a scan
    do_load({$urandom, $urandom});
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_idx", 64'({ifa.eval_row, ifa.eval_col}), 64'd30);
    #1 rst_n = 1'b0;
    #1 chk_reset("mid_scan_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mb_a = '0; mb_b = '0; gen_a = 0; gen_b = 0; st_a = 1'b0; st_b = 1'b0;
    repeat (70) @(negedge clk);
    chk_state("post_rst");
    do_load({$urandom, $urandom});
    do_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
